wm8731_cfg_sequencer: RTL and testbench
=======================================

// Module: wm8731_cfg_sequencer
// PURPOSE
//  Sequences the byte-level i2c command engine (start/stop/write, cmd_done/cmd_status) to load the WM8731 codec
//  with a fixed register table after reset or on request. Each table entry becomes one frame:
//  START, dev addr, {reg[6:0],data[8]}, data[7:0], STOP. Sits between top level and the i2c instance; audio_codec streams only after cfg_done.
// PARAMETERS
//  N_REGS        8          number of table entries (1..16)
//  DEV_ADDR      7'h1A      codec 7-bit i2c address (CSB=0); wire byte = {DEV_ADDR,1'b0} = 8'h34
//  TIMEOUT_CYC   500_000    sys_clk cycles allowed per handshake phase before abort
//  MAX_RETRY     3          frame retries after NACK (used only with WM8731_RETRY_EN)
// PORTS
//  sys_clk     in   1   system clock, 50 MHz
//  rst         in   1   reset: asynchronous, active-low
//  go          in   1   1-cycle pulse: (re)start sequence from entry 0; ignored while busy
//  i2c_start   out  1   request START condition
//  i2c_stop    out  1   request STOP condition
//  i2c_write   out  1   request byte write of i2c_data
//  i2c_data    out  8   byte to write, stable while i2c_write=1
//  i2c_done    in   1   engine command complete (4-phase ack)
//  i2c_status  in   1   valid with i2c_done after write: 0=ACK, 1=NACK
//  cfg_busy    out  1   sequence in progress
//  cfg_done    out  1   all N_REGS entries acknowledged; sticky until next go
//  cfg_error   out  1   abort (NACK/timeout); sticky until next go
//  cfg_err_idx out  4   table index of failing entry
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index 0. Sequence auto-starts in the 1st cycle after rst deasserts (internal go).
//  Handshake per command (4-phase): raise exactly one request; hold until i2c_done=1; sample i2c_status;
//   drop request; wait i2c_done=0 before next request. Never two requests high at once.
//  FSM: IDLE -> START -> DEV -> RHI -> DLO -> STOP -> NEXT -> (START | FIN); ERR.
//   Each command state has REQ/REL sub-phase; i2c_data loaded in the cycle the request rises.
//  NEXT: index==N_REGS-1 -> FIN (cfg_done=1, busy=0) else index+1, START.
//  NACK on any write: finish remaining flow by going straight to STOP, then retry/ERR (see CONFIGURATION).
//  Timeout: counter cleared on each phase change; reaching TIMEOUT_CYC -> ERR at once, all requests low, no STOP.
//  ERR: cfg_error=1, cfg_err_idx=index, busy=0. go from FIN/ERR clears done/error, index=0, restarts.
//  go while busy: ignored. i2c_done=1 while no request pending: ignored (no state change).
//  rst asserted mid-frame: requests drop immediately (async); engine may leave bus mid-frame, its own reset handles it.
//  Latency per frame: 5 handshakes; no added cycles beyond 1 per phase edge.
// CONFIGURATION
//  WM8731_RETRY_EN defined: after NACK+STOP, retry same entry from START up to MAX_RETRY times (counter per entry, cleared on NEXT);
//   exhausted -> ERR. Undefined: first NACK -> STOP -> ERR; no retry counter synthesized.
// STRUCTURE
//  Package wm8731_pkg: register address localparams (R_LLIN..R_RESET=4'hF), state encoding, default table values.
//  Sub-module wm8731_cfg_rom: combinational index(4) -> {reg[6:0],data[8:0]}; defaults in order:
//   R15=0x000, R6=0x000, R4=0x012, R5=0x000, R7=0x00A (I2S,24-bit,slave), R8=0x000, R2=0x079, R9=0x001.
// TESTING
//  1 Reset release, ideal ACKing engine model -> 8 frames; entry0 bytes 34,1E,00; entry2 34,08,12; entry7 34,12,01; cfg_done=1.
//  2 NACK on RHI byte of entry 4 (no RETRY_EN) -> STOP issued, cfg_error=1, cfg_err_idx=4, no further START.
//  3 RETRY_EN, entry 3 NACKs twice then ACKs -> 3 frames for entry 3, sequence completes, cfg_done=1.
//  4 RETRY_EN, entry 1 always NACK -> 4 attempts then cfg_error=1, cfg_err_idx=1.
//  5 Engine never asserts i2c_done on entry 5 DEV -> after TIMEOUT_CYC (bench 100) cfg_error=1, all requests 0.
//  6 go pulse mid-sequence -> ignored; rst low mid-frame -> outputs 0 next edge-free instant; release -> restart entry 0.
//  Checker on every run: mutual exclusion of requests; no request rise while i2c_done=1.

Source files
------------

// File: rtl/wm8731_pkg.sv
// -----------------------------------------------------------------------------
// wm8731_pkg
// Shared definitions for the WM8731 configuration sequencer:
//   - WM8731 control register addresses (7-bit register field of the I2C word)
//   - table entry layout {reg[6:0], data[8:0]}
//   - sequencer state / handshake sub-phase encodings
//   - default_entry(): the power-up register table, in load order
// -----------------------------------------------------------------------------
package wm8731_pkg;

  // WM8731 register map
  localparam logic [6:0] R_LLIN  = 7'h00;  // left line in
  localparam logic [6:0] R_RLIN  = 7'h01;  // right line in
  localparam logic [6:0] R_LHPO  = 7'h02;  // left headphone out
  localparam logic [6:0] R_RHPO  = 7'h03;  // right headphone out
  localparam logic [6:0] R_AAPC  = 7'h04;  // analogue audio path
  localparam logic [6:0] R_DAPC  = 7'h05;  // digital audio path
  localparam logic [6:0] R_PDC   = 7'h06;  // power down control
  localparam logic [6:0] R_DAIF  = 7'h07;  // digital audio interface format
  localparam logic [6:0] R_SRC   = 7'h08;  // sampling control
  localparam logic [6:0] R_ACT   = 7'h09;  // active control
  localparam logic [6:0] R_RESET = 7'h0F;  // reset register

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

  // Sequencer states (legacy-compatible constant encoding)
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_DEV   = 4'd2;
  localparam logic [3:0] S_RHI   = 4'd3;
  localparam logic [3:0] S_DLO   = 4'd4;
  localparam logic [3:0] S_STOP  = 4'd5;
  localparam logic [3:0] S_NEXT  = 4'd6;
  localparam logic [3:0] S_FIN   = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  // Handshake sub-phase inside each command state
  localparam logic PH_REQ = 1'b0;  // request high, waiting for done=1
  localparam logic PH_REL = 1'b1;  // request low, waiting for done=0

  // Power-up table: reset first, power-down bits, analogue path, then
  // interface format (I2S, 24-bit, slave) and finally activate.
  function automatic cfg_entry_t default_entry(input logic [3:0] idx);
    cfg_entry_t e;
    case (idx)
      4'd0:    e = {R_RESET, 9'h000};
      4'd1:    e = {R_PDC,   9'h000};
      4'd2:    e = {R_AAPC,  9'h012};
      4'd3:    e = {R_DAPC,  9'h000};
      4'd4:    e = {R_DAIF,  9'h00A};
      4'd5:    e = {R_SRC,   9'h000};
      4'd6:    e = {R_LHPO,  9'h079};
      4'd7:    e = {R_ACT,   9'h001};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_rom
// Combinational register table lookup.
// Ports:
//   idx       in  4  table index
//   reg_addr  out 7  WM8731 register address of entry idx
//   reg_data  out 9  9-bit register value of entry idx
// Indices past the populated table return zero.
// -----------------------------------------------------------------------------
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0] idx,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data
);

  cfg_entry_t entry;

  always_comb begin
    entry    = default_entry(idx);
    reg_addr = entry.addr;
    reg_data = entry.data;
  end

endmodule

// File: rtl/wm8731_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_sequencer
// Drives a byte-level I2C command engine to load the WM8731 register table.
// Every table entry becomes one frame: START, {DEV_ADDR,0}, {reg,data[8]},
// data[7:0], STOP. Each command is a 4-phase handshake with the engine.
//
// Ports:
//   sys_clk      in   1  system clock
//   rst          in   1  asynchronous active-low reset
//   go           in   1  restart pulse (ignored while busy)
//   i2c_start    out  1  request START
//   i2c_stop     out  1  request STOP
//   i2c_write    out  1  request write of i2c_data
//   i2c_data     out  8  byte to write
//   i2c_done     in   1  engine command complete
//   i2c_status   in   1  0=ACK, 1=NACK (valid with i2c_done after a write)
//   cfg_busy     out  1  sequence in progress
//   cfg_done     out  1  whole table acknowledged (sticky until go)
//   cfg_error    out  1  aborted on NACK/timeout (sticky until go)
//   cfg_err_idx  out  4  index of the failing entry
//
// Build option: define WM8731_RETRY_EN to retry a NACKed frame up to
// MAX_RETRY times before aborting. Without it the first NACK aborts.
// -----------------------------------------------------------------------------
module wm8731_cfg_sequencer
  import wm8731_pkg::*;
#(
  parameter int         N_REGS      = 8,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         TIMEOUT_CYC = 500_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       go,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic       i2c_write,
  output logic [7:0] i2c_data,
  input  logic       i2c_done,
  input  logic       i2c_status,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] cfg_err_idx
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]    LAST_IDX = 4'(N_REGS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  if (N_REGS < 1 || N_REGS > 16) begin : g_bad_n_regs
    $error("wm8731_cfg_sequencer: N_REGS must be 1..16");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 255) begin : g_bad_max_retry
    $error("wm8731_cfg_sequencer: MAX_RETRY must be 1..255");
  end

  logic [3:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [3:0]    idx_q,   idx_d;
  logic          nack_q,  nack_d;
  logic          boot_q,  boot_d;
  logic [7:0]    data_q,  data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          enter_req;
  logic          is_write;
  logic [6:0]    rom_addr;
  logic [8:0]    rom_data;

`ifdef WM8731_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  wm8731_cfg_rom u_rom (
    .idx      (idx_q),
    .reg_addr (rom_addr),
    .reg_data (rom_data)
  );

  assign is_write = (state_q == S_DEV) || (state_q == S_RHI) || (state_q == S_DLO);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned; that is what keeps this block latch-free.
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    nack_d    = nack_q;
    data_d    = data_q;
    boot_d    = 1'b0;
    timer_d   = '0;
    enter_req = 1'b0;
`ifdef WM8731_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        // boot_q is the internal go issued in the first cycle after reset.
        if (go || boot_q) begin
          idx_d     = '0;
          nack_d    = 1'b0;
          state_d   = S_START;
          phase_d   = PH_REQ;
          enter_req = 1'b1;
`ifdef WM8731_RETRY_EN
          retry_d   = '0;
`endif
        end
      end

      S_NEXT: begin
        nack_d = 1'b0;
`ifdef WM8731_RETRY_EN
        retry_d = '0;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d     = idx_q + 4'd1;
          state_d   = S_START;
          phase_d   = PH_REQ;
          enter_req = 1'b1;
        end
      end

      S_START, S_DEV, S_RHI, S_DLO, S_STOP: begin
        if (phase_q == PH_REQ && i2c_done) begin
          if (is_write && i2c_status) nack_d = 1'b1;
          phase_d = PH_REL;
        end else if (phase_q == PH_REL && !i2c_done) begin
          // Engine has released done: advance to the next command. After a
          // NACK the rest of the frame is skipped and STOP is issued at once.
          phase_d   = PH_REQ;
          enter_req = 1'b1;
          case (state_q)
            S_START: state_d = S_DEV;
            S_DEV:   state_d = nack_q ? S_STOP : S_RHI;
            S_RHI:   state_d = nack_q ? S_STOP : S_DLO;
            S_DLO:   state_d = S_STOP;
            default: begin
              enter_req = 1'b0;
              if (!nack_q) begin
                state_d = S_NEXT;
              end else begin
`ifdef WM8731_RETRY_EN
                if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d   = retry_q + 1'b1;
                  nack_d    = 1'b0;
                  state_d   = S_START;
                  enter_req = 1'b1;
                end else begin
                  state_d = S_ERR;
                end
`else
                state_d = S_ERR;
`endif
              end
            end
          endcase
        end else if (timer_q == TO_LAST) begin
          // Engine stuck in this phase: abandon the frame without a STOP.
          state_d = S_ERR;
          phase_d = PH_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = PH_REQ;
      end
    endcase

    // The write byte is captured in the same cycle its request rises, so it
    // is already stable on the first cycle i2c_write is seen high.
    if (enter_req) begin
      case (state_d)
        S_DEV:   data_d = {DEV_ADDR, 1'b0};
        S_RHI:   data_d = {rom_addr, rom_data[8]};
        S_DLO:   data_d = rom_data[7:0];
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_REQ;
      idx_q   <= '0;
      nack_q  <= 1'b0;
      boot_q  <= 1'b1;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      nack_q  <= nack_d;
      boot_q  <= boot_d;
      data_q  <= data_d;
      timer_q <= timer_d;
    end
  end

`ifdef WM8731_RETRY_EN
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) retry_q <= '0;
    else      retry_q <= retry_d;
  end
`endif

  // Requests decode straight from state so an asserted reset drops them
  // without waiting for a clock edge.
  assign i2c_start   = (state_q == S_START) && (phase_q == PH_REQ);
  assign i2c_stop    = (state_q == S_STOP)  && (phase_q == PH_REQ);
  assign i2c_write   = is_write && (phase_q == PH_REQ);
  assign i2c_data    = data_q;
  assign cfg_busy    = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_ERR);
  assign cfg_done    = (state_q == S_FIN);
  assign cfg_error   = (state_q == S_ERR);
  assign cfg_err_idx = (state_q == S_ERR) ? idx_q : 4'd0;

endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wm8731_cfg_sequencer
// Directed bench: an I2C command engine model answers the sequencer's
// requests (optionally NACKing or hanging), a protocol monitor watches the
// handshake, and a table of scenarios plus a few hand sequences are checked.
// -----------------------------------------------------------------------------
module tb_wm8731_cfg_sequencer;

  localparam int TO_CYC    = 100;
  localparam int TOK_START = 256;
  localparam int TOK_STOP  = 257;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       go;
  logic       i2c_start, i2c_stop, i2c_write;
  logic [7:0] i2c_data;
  logic       i2c_done, i2c_status;
  logic       cfg_busy, cfg_done, cfg_error;
  logic [3:0] cfg_err_idx;

  wm8731_cfg_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .go          (go),
    .i2c_start   (i2c_start),
    .i2c_stop    (i2c_stop),
    .i2c_write   (i2c_write),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_status  (i2c_status),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .cfg_err_idx (cfg_err_idx)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- engine model configuration (written by the test) -------
  int cfg_nack_ent = -1;  // entry whose frame NACKs
  int cfg_nack_pos = 0;   // 1=dev byte, 2=reg/hi byte, 3=data low byte
  int cfg_nack_cnt = 0;   // how many frames of that entry NACK
  int cfg_hang_ent = -1;  // entry whose dev byte never gets i2c_done

  // ---------------- engine model state (written by the engine only) --------
  int log_q[$];
  int n_starts   = 0;
  int eng_ent    = 0;
  int eng_pos    = 0;
  int nack_given = 0;
  int hang_cyc   = -1;
  bit eng_nacked = 1'b0;

  initial begin : engine
    i2c_done   = 1'b0;
    i2c_status = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (!rst) begin
        i2c_done   = 1'b0;
        i2c_status = 1'b0;
        log_q.delete();
        n_starts   = 0;
        eng_ent    = 0;
        eng_pos    = 0;
        nack_given = 0;
        hang_cyc   = -1;
        eng_nacked = 1'b0;
      end else if (i2c_done) begin
        if (!(i2c_start || i2c_stop || i2c_write)) begin
          i2c_done   = 1'b0;
          i2c_status = 1'b0;
        end
      end else if (i2c_start) begin
        log_q.push_back(TOK_START);
        n_starts++;
        eng_pos    = 0;
        eng_nacked = 1'b0;
        i2c_status = 1'b0;
        i2c_done   = 1'b1;
      end else if (i2c_stop) begin
        log_q.push_back(TOK_STOP);
        if (!eng_nacked) eng_ent++;
        i2c_status = 1'b0;
        i2c_done   = 1'b1;
      end else if (i2c_write) begin
        if (eng_ent == cfg_hang_ent && eng_pos == 0) begin
          if (hang_cyc < 0) hang_cyc = cyc;
        end else begin
          eng_pos++;
          log_q.push_back(int'(i2c_data));
          if (eng_ent == cfg_nack_ent && eng_pos == cfg_nack_pos && nack_given < cfg_nack_cnt) begin
            nack_given++;
            eng_nacked = 1'b1;
            i2c_status = 1'b1;
          end else begin
            i2c_status = 1'b0;
          end
          i2c_done = 1'b1;
        end
      end
    end
  end

  // ---------------- handshake monitor ---------------------------------------
  int         proto_viol = 0;
  logic       req_prev   = 1'b0;
  logic       done_prev  = 1'b0;
  logic       wr_prev    = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  always @(negedge sys_clk) begin
    if (rst) begin
      if (int'(i2c_start) + int'(i2c_stop) + int'(i2c_write) > 1) begin
        proto_viol <= proto_viol + 1;
        $display("protocol: two requests high at t=%0t", $time);
      end
      if ((i2c_start || i2c_stop || i2c_write) && !req_prev && done_prev) begin
        proto_viol <= proto_viol + 1;
        $display("protocol: request rose while i2c_done=1 at t=%0t", $time);
      end
      if (i2c_write && wr_prev && i2c_data != data_prev) begin
        proto_viol <= proto_viol + 1;
        $display("protocol: i2c_data changed during write at t=%0t", $time);
      end
    end
    req_prev  <= i2c_start || i2c_stop || i2c_write;
    done_prev <= i2c_done;
    wr_prev   <= i2c_write;
    data_prev <= i2c_data;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus tables ------------------------------------------
  typedef struct packed {
    int nack_ent;
    int nack_pos;
    int nack_cnt;
    int hang_ent;
    bit exp_done;
    bit exp_err;
    int exp_idx;
    int exp_starts;
    int exp_last;
  } vec_t;

  typedef struct packed {
    int rhi;
    int dlo;
  } frame_t;

  vec_t   vecs[$];
  frame_t frames[8];

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (cfg_done || cfg_error) ok = 1'b1;
    end
  endtask

  task automatic pulse_go();
    @(negedge sys_clk); go = 1'b1;
    @(negedge sys_clk); go = 1'b0;
  endtask

  task automatic set_faults(input int ne, input int np, input int nc, input int he);
    cfg_nack_ent = ne;
    cfg_nack_pos = np;
    cfg_nack_cnt = nc;
    cfg_hang_ent = he;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " reqs/flags"},
          {26'd0, i2c_start, i2c_stop, i2c_write, cfg_busy, cfg_done, cfg_error}, 32'd0);
    check({name, " data/idx"}, {20'd0, i2c_data, cfg_err_idx}, 32'd0);
  endtask

  task automatic check_frames();
    check("v0 log length", log_q.size(), 40);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("entry%0d start", k), log_q[5*k],     TOK_START);
      check($sformatf("entry%0d dev",   k), log_q[5*k + 1], 32'h34);
      check($sformatf("entry%0d rhi",   k), log_q[5*k + 2], frames[k].rhi);
      check($sformatf("entry%0d dlo",   k), log_q[5*k + 3], frames[k].dlo);
      check($sformatf("entry%0d stop",  k), log_q[5*k + 4], TOK_STOP);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    bit ok;
    int base;
    set_faults(v.nack_ent, v.nack_pos, v.nack_cnt, v.hang_ent);
    rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_outputs_zero($sformatf("v%0d in reset", k));
    @(negedge sys_clk); rst = 1'b1;
    base = proto_viol;
    @(posedge sys_clk); #1;
    check($sformatf("v%0d autostart", k), i2c_start, 1'b1);
    wait_end(3000, ok);
    check($sformatf("v%0d finished in budget", k), ok, 1'b1);
    if (v.hang_ent >= 0)
      check($sformatf("v%0d timeout cycles", k), cyc - hang_cyc, TO_CYC);
    repeat (20) @(posedge sys_clk);
    #1;
    check($sformatf("v%0d cfg_done", k),    cfg_done,    v.exp_done);
    check($sformatf("v%0d cfg_error", k),   cfg_error,   v.exp_err);
    check($sformatf("v%0d cfg_err_idx", k), cfg_err_idx, v.exp_idx);
    check($sformatf("v%0d busy/reqs", k), {i2c_start, i2c_stop, i2c_write, cfg_busy}, 4'b0000);
    check($sformatf("v%0d START count", k), n_starts, v.exp_starts);
    check($sformatf("v%0d last bus token", k), log_q[log_q.size() - 1], v.exp_last);
    check($sformatf("v%0d protocol", k), proto_viol - base, 0);
  endtask

  initial begin : main
    bit ok;
    int base;
    rst = 1'b0;
    go  = 1'b0;

    // Expected bytes 2 and 3 of every frame: {reg,data[8]} and data[7:0].
    frames[0] = '{32'h1E, 32'h00};  // R15 reset
    frames[1] = '{32'h0C, 32'h00};  // R6
    frames[2] = '{32'h08, 32'h12};  // R4
    frames[3] = '{32'h0A, 32'h00};  // R5
    frames[4] = '{32'h0E, 32'h0A};  // R7 I2S 24-bit slave
    frames[5] = '{32'h10, 32'h00};  // R8
    frames[6] = '{32'h04, 32'h79};  // R2
    frames[7] = '{32'h12, 32'h01};  // R9 active

    //                     nack_ent pos cnt hang  done err idx starts last
    vecs.push_back(vec_t'{-1, 0, 0,  -1, 1'b1, 1'b0, 0, 8,  TOK_STOP});
    vecs.push_back(vec_t'{-1, 0, 0,   5, 1'b0, 1'b1, 5, 6,  TOK_START});
`ifdef WM8731_RETRY_EN
    vecs.push_back(vec_t'{ 4, 2, 99, -1, 1'b0, 1'b1, 4, 8,  TOK_STOP});
    vecs.push_back(vec_t'{ 2, 1, 1,  -1, 1'b1, 1'b0, 0, 9,  TOK_STOP});
    vecs.push_back(vec_t'{ 7, 3, 1,  -1, 1'b1, 1'b0, 0, 9,  TOK_STOP});
    vecs.push_back(vec_t'{ 3, 2, 2,  -1, 1'b1, 1'b0, 0, 10, TOK_STOP});
    vecs.push_back(vec_t'{ 1, 1, 99, -1, 1'b0, 1'b1, 1, 5,  TOK_STOP});
`else
    vecs.push_back(vec_t'{ 4, 2, 99, -1, 1'b0, 1'b1, 4, 5,  TOK_STOP});
    vecs.push_back(vec_t'{ 2, 1, 1,  -1, 1'b0, 1'b1, 2, 3,  TOK_STOP});
    vecs.push_back(vec_t'{ 7, 3, 1,  -1, 1'b0, 1'b1, 7, 8,  TOK_STOP});
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      run_vec(vecs[k], k);
      if (k == 0) check_frames();
    end

    // go pulse while busy is ignored.
    set_faults(-1, 0, 0, -1);
    rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); rst = 1'b1;
    base = proto_viol;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (n_starts >= 4) ok = 1'b1;
    end
    check("busy-go reached entry 3", ok, 1'b1);
    pulse_go();
    wait_end(3000, ok);
    repeat (5) @(posedge sys_clk);
    #1;
    check("busy-go cfg_done", cfg_done, 1'b1);
    check("busy-go START count", n_starts, 8);

    // go from FIN clears done and replays the whole table.
    pulse_go();
    @(posedge sys_clk); #1;
    check("fin-go clears done, busy", {cfg_done, cfg_busy}, 2'b01);
    wait_end(3000, ok);
    check("fin-go cfg_done", cfg_done, 1'b1);
    check("fin-go START count", n_starts, 16);

    // Reset mid-frame drops every output with no clock edge, then restarts.
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (n_starts == 19 && i2c_write) ok = 1'b1;
    end
    check("mid-frame write seen", ok, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_outputs_zero("async reset");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); rst = 1'b1;
    wait_end(3000, ok);
    repeat (5) @(posedge sys_clk);
    #1;
    check("restart cfg_done", cfg_done, 1'b1);
    check("restart START count", n_starts, 8);
    check("restart first reg byte", log_q[2], 32'h1E);
    check("hand sequences protocol", proto_viol - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
